fault_monitor: RTL and testbench

FAULT_MONITOR -- requirements
Module: fault_monitor

---
 rtl/coffee_machine_pkg.sv | 35 +++
 rtl/fault_filter.sv | 44 ++++
 rtl/fault_monitor.sv | 144 ++++++++++++++
 tb/tb_fault_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/coffee_machine_pkg.sv
// Shared fault-source indices, default monitor configuration and small bit-vector helpers.
package coffee_machine_pkg;

   localparam int FAULT_NO_WATER     = 0;
   localparam int FAULT_OVERTEMP     = 1;
   localparam int FAULT_PRESSURE     = 2;
   localparam int FAULT_DESCALE      = 3;
   localparam int FAULT_BEANS_EMPTY  = 4;
   localparam int FAULT_GROUNDS_FULL = 5;
   localparam int FAULT_DRIP_TRAY    = 6;
   localparam int FAULT_DOOR_OPEN    = 7;

   localparam int         DEFAULT_NUM_FAULTS    = 8;
   localparam logic [7:0] DEFAULT_CRITICAL_MASK = 8'b0000_0111;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b000, v[i]};
      end
      return cnt;
   endfunction

   // Returns 0 for an all-zero vector; callers qualify with their own non-zero test.
   function automatic logic [2:0] lowest_set8(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/fault_filter.sv
// Per-source persistence filter: filt toggles after raw has disagreed for DEBOUNCE_CYCLES samples.
// rise is a combinational look-ahead, high in the cycle before filt goes 0->1.
module fault_filter
#(
   parameter int DEBOUNCE_CYCLES = 1000
)(
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filt,
   output logic rise
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          filt_q, filt_d;

   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (raw != filt_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            filt_d = ~filt_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign filt = filt_q;
   assign rise = filt_d & ~filt_q;

endmodule

// File: rtl/fault_monitor.sv
// Debounced fault aggregation: critical latches, warning status, counts, first-fault capture.
// Outputs registered, DEBOUNCE_CYCLES+1 clocks from steady raw change; optional history via FAULT_HISTORY_EN.
module fault_monitor
   import coffee_machine_pkg::*;
#(
   parameter int                    NUM_FAULTS      = DEFAULT_NUM_FAULTS,
   parameter int                    DEBOUNCE_CYCLES = 1000,
   parameter logic [NUM_FAULTS-1:0] CRITICAL_MASK   = DEFAULT_CRITICAL_MASK[NUM_FAULTS-1:0]
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FAULTS-1:0] fault_raw,
   input  logic                  clear_req,
   output logic                  critical_error,
   output logic                  error_present,
   output logic [3:0]            error_count,
   output logic [3:0]            warning_count,
   output logic [NUM_FAULTS-1:0] fault_active,
   output logic [2:0]            first_fault_id,
   output logic                  first_fault_valid,
   input  logic [2:0]            hist_sel,
   output logic [7:0]            hist_count
);

   logic [NUM_FAULTS-1:0] filt, rise;
   logic [NUM_FAULTS-1:0] latch_q, latch_d;
   logic [NUM_FAULTS-1:0] clr_mask, survive, warn;
   logic [2:0]            ff_id_q, ff_id_d;

   logic                  critical_error_q, critical_error_d;
   logic                  error_present_q, error_present_d;
   logic [3:0]            error_count_q, error_count_d;
   logic [3:0]            warning_count_q, warning_count_d;
   logic [NUM_FAULTS-1:0] fault_active_q, fault_active_d;
   logic [2:0]            first_fault_id_q, first_fault_id_d;
   logic                  first_fault_valid_q, first_fault_valid_d;

   for (genvar g = 0; g < NUM_FAULTS; g++) begin : g_filt
      fault_filter #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_fault_filter (
         .clk  (clk),
         .rst  (rst),
         .raw  (fault_raw[g]),
         .filt (filt[g]),
         .rise (rise[g])
      );
   end

   // Latches update on the same edge as the filter so outputs land one clock later.
   always_comb begin
      clr_mask = {NUM_FAULTS{clear_req}} & ~filt;
      survive  = latch_q & ~clr_mask;
      latch_d  = survive | (rise & CRITICAL_MASK);
      warn     = filt & ~CRITICAL_MASK;

      ff_id_d = ff_id_q;
      if (latch_d == '0) begin
         ff_id_d = 3'd0;
      end else if (survive == '0) begin
         ff_id_d = lowest_set8(8'(latch_d));
      end

      critical_error_d    = |latch_q;
      error_present_d     = (|latch_q) | (|warn);
      error_count_d       = popcount8(8'(latch_q));
      warning_count_d     = popcount8(8'(warn));
      fault_active_d      = latch_q | warn;
      first_fault_valid_d = |latch_q;
      first_fault_id_d    = ff_id_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         latch_q             <= '0;
         ff_id_q             <= 3'd0;
         critical_error_q    <= 1'b0;
         error_present_q     <= 1'b0;
         error_count_q       <= 4'd0;
         warning_count_q     <= 4'd0;
         fault_active_q      <= '0;
         first_fault_id_q    <= 3'd0;
         first_fault_valid_q <= 1'b0;
      end else begin
         latch_q             <= latch_d;
         ff_id_q             <= ff_id_d;
         critical_error_q    <= critical_error_d;
         error_present_q     <= error_present_d;
         error_count_q       <= error_count_d;
         warning_count_q     <= warning_count_d;
         fault_active_q      <= fault_active_d;
         first_fault_id_q    <= first_fault_id_d;
         first_fault_valid_q <= first_fault_valid_d;
      end
   end

   assign critical_error    = critical_error_q;
   assign error_present     = error_present_q;
   assign error_count       = error_count_q;
   assign warning_count     = warning_count_q;
   assign fault_active      = fault_active_q;
   assign first_fault_id    = first_fault_id_q;
   assign first_fault_valid = first_fault_valid_q;

`ifdef FAULT_HISTORY_EN
   logic [7:0] hist_q [NUM_FAULTS];
   logic [7:0] hist_d [NUM_FAULTS];
   logic [7:0] hist_count_q, hist_count_d;

   always_comb begin
      for (int i = 0; i < NUM_FAULTS; i++) begin
         hist_d[i] = hist_q[i];
         if (rise[i] && (hist_q[i] != 8'hFF)) begin
            hist_d[i] = hist_q[i] + 8'd1;
         end
      end
      hist_count_d = 8'd0;
      if (int'(hist_sel) < NUM_FAULTS) begin
         hist_count_d = hist_q[hist_sel];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_FAULTS; i++) begin
            hist_q[i] <= 8'd0;
         end
         hist_count_q <= 8'd0;
      end else begin
         for (int i = 0; i < NUM_FAULTS; i++) begin
            hist_q[i] <= hist_d[i];
         end
         hist_count_q <= hist_count_d;
      end
   end

   assign hist_count = hist_count_q;
`else
   logic unused_hist_sel;
   assign unused_hist_sel = ^hist_sel;
   assign hist_count      = 8'd0;
`endif

endmodule

// File: tb/tb_fault_monitor.sv
// Directed bench for fault_monitor with DEBOUNCE_CYCLES=4 and the default critical mask (sources 0..2).
module tb_fault_monitor;
   import coffee_machine_pkg::*;

   localparam int NF = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [NF-1:0] fault_raw;
   logic          clear_req;
   logic          critical_error, error_present, first_fault_valid;
   logic [3:0]    error_count, warning_count;
   logic [NF-1:0] fault_active;
   logic [2:0]    first_fault_id, hist_sel;
   logic [7:0]    hist_count;

   int checks   = 0;
   int failures = 0;

   fault_monitor #(
      .NUM_FAULTS      (NF),
      .DEBOUNCE_CYCLES (4),
      .CRITICAL_MASK   (8'b0000_0111)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .fault_raw         (fault_raw),
      .clear_req         (clear_req),
      .critical_error    (critical_error),
      .error_present     (error_present),
      .error_count       (error_count),
      .warning_count     (warning_count),
      .fault_active      (fault_active),
      .first_fault_id    (first_fault_id),
      .first_fault_valid (first_fault_valid),
      .hist_sel          (hist_sel),
      .hist_count        (hist_count)
   );

   always #10 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_crit"},  32'(critical_error),    0);
      chk({tag, "_pres"},  32'(error_present),     0);
      chk({tag, "_ecnt"},  32'(error_count),       0);
      chk({tag, "_wcnt"},  32'(warning_count),     0);
      chk({tag, "_act"},   32'(fault_active),      0);
      chk({tag, "_ffid"},  32'(first_fault_id),    0);
      chk({tag, "_ffvld"}, 32'(first_fault_valid), 0);
      chk({tag, "_hist"},  32'(hist_count),        0);
   endtask

   initial begin
      rst       = 1'b1;
      fault_raw = '0;
      clear_req = 1'b0;
      hist_sel  = 3'd0;
      @(negedge clk);
      tick(2);
      rst = 1'b0;
      chk_all_zero("reset");

      // Glitch shorter than the window on a warning source
      fault_raw[FAULT_GROUNDS_FULL] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("glitch_hi_wcnt", 32'(warning_count), 0);
         chk("glitch_hi_pres", 32'(error_present), 0);
      end
      fault_raw[FAULT_GROUNDS_FULL] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         chk("glitch_lo_wcnt", 32'(warning_count), 0);
         chk("glitch_lo_pres", 32'(error_present), 0);
         chk("glitch_lo_act",  32'(fault_active),  0);
      end

      // Warning: exactly 5 clocks to appear and to disappear
      fault_raw[FAULT_BEANS_EMPTY] = 1'b1;
      tick(4);
      chk("warn_early_wcnt", 32'(warning_count), 0);
      tick(1);
      chk("warn_wcnt", 32'(warning_count),  1);
      chk("warn_pres", 32'(error_present),  1);
      chk("warn_crit", 32'(critical_error), 0);
      chk("warn_act",  32'(fault_active),   32'h10);
      clear_req = 1'b1;
      tick(1);
      clear_req = 1'b0;
      chk("warn_clr_wcnt", 32'(warning_count), 1);
      fault_raw[FAULT_BEANS_EMPTY] = 1'b0;
      tick(4);
      chk("warn_fall_early", 32'(warning_count), 1);
      tick(1);
      chk("warn_fall_wcnt", 32'(warning_count), 0);
      chk("warn_fall_pres", 32'(error_present), 0);

      // Critical latch on source 1, held for 6 samples
      fault_raw[FAULT_OVERTEMP] = 1'b1;
      tick(4);
      chk("crit_early", 32'(critical_error), 0);
      tick(1);
      chk("crit_err",   32'(critical_error),    1);
      chk("crit_ffid",  32'(first_fault_id),    1);
      chk("crit_ffvld", 32'(first_fault_valid), 1);
      chk("crit_ecnt",  32'(error_count),       1);
      tick(1);
      fault_raw[FAULT_OVERTEMP] = 1'b0;
      clear_req = 1'b1;
      tick(1);
      clear_req = 1'b0;
      tick(1);
      chk("crit_clr_while_hi", 32'(critical_error), 1);
      tick(2);
      chk("crit_hold_err", 32'(critical_error), 1);
      chk("crit_hold_act", 32'(fault_active),   32'h02);
      clear_req = 1'b1;
      tick(1);
      clear_req = 1'b0;
      chk("crit_clr_lat", 32'(critical_error), 1);
      tick(1);
      chk("crit_clr_err",   32'(critical_error),    0);
      chk("crit_clr_ffvld", 32'(first_fault_valid), 0);
      chk("crit_clr_ffid",  32'(first_fault_id),    0);
      chk("crit_clr_pres",  32'(error_present),     0);

      // Simultaneous criticals 0 and 2 plus warning 4
      fault_raw = 8'h15;
      tick(5);
      chk("sim_ecnt", 32'(error_count),   2);
      chk("sim_wcnt", 32'(warning_count), 1);
      chk("sim_ffid", 32'(first_fault_id), 0);
      chk("sim_act",  32'(fault_active),  32'h15);

      // Third critical rises on the same edge as clear_req: set wins
      fault_raw[FAULT_OVERTEMP] = 1'b1;
      tick(3);
      clear_req = 1'b1;
      tick(1);
      clear_req = 1'b0;
      tick(1);
      chk("setwin_ecnt", 32'(error_count),    3);
      chk("setwin_ffid", 32'(first_fault_id), 0);
      chk("setwin_act",  32'(fault_active),   32'h17);

      // Drop source 1 and clear it, leaving two criticals and one warning
      fault_raw[FAULT_OVERTEMP] = 1'b0;
      tick(4);
      clear_req = 1'b1;
      tick(1);
      clear_req = 1'b0;
      hist_sel = 3'd1;
      tick(1);
      chk("pre_rst_ecnt",  32'(error_count),       2);
      chk("pre_rst_wcnt",  32'(warning_count),     1);
      chk("pre_rst_ffvld", 32'(first_fault_valid), 1);
      chk("pre_rst_ffid",  32'(first_fault_id),    0);
`ifdef FAULT_HISTORY_EN
      chk("pre_rst_hist1", 32'(hist_count), 2);
`else
      chk("pre_rst_hist1", 32'(hist_count), 0);
`endif

      // Reset mid-operation, then filtering restarts from zero
      rst = 1'b1;
      tick(1);
      chk_all_zero("midrst");
      fault_raw = 8'h20;
      tick(1);
      chk("rst_held_wcnt", 32'(warning_count), 0);
      rst = 1'b0;
      tick(4);
      chk("restart_early", 32'(warning_count), 0);
      tick(1);
      chk("restart_wcnt", 32'(warning_count), 1);
      fault_raw = '0;
      tick(6);
      chk("restart_fall", 32'(warning_count), 0);

      // History on source 3
      hist_sel = 3'd3;
      for (int p = 0; p < 3; p++) begin
         fault_raw[FAULT_DESCALE] = 1'b1;
         tick(4);
         fault_raw[FAULT_DESCALE] = 1'b0;
         tick(4);
      end
      tick(1);
`ifdef FAULT_HISTORY_EN
      chk("hist3_x3", 32'(hist_count), 3);
      hist_sel = 3'd5;
      tick(2);
      chk("hist5_x1", 32'(hist_count), 1);
      hist_sel = 3'd3;
      for (int p = 0; p < 297; p++) begin
         fault_raw[FAULT_DESCALE] = 1'b1;
         tick(4);
         fault_raw[FAULT_DESCALE] = 1'b0;
         tick(4);
      end
      tick(1);
      chk("hist3_sat", 32'(hist_count), 255);
`else
      chk("hist_off_3", 32'(hist_count), 0);
      hist_sel = 3'd5;
      tick(2);
      chk("hist_off_5", 32'(hist_count), 0);
`endif
      chk("final_wcnt", 32'(warning_count), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
